// File: rtl/nn_pkg.sv
// Shared defaults, state encoding and activation limits for the neuron datapath.
package nn_pkg;

  localparam int unsigned NN_PROD_W   = 16;
  localparam int unsigned NN_ACC_W    = 32;
  localparam int unsigned NN_N_INPUTS = 784;
  localparam int unsigned NN_OUT_W    = 8;
  localparam int unsigned NN_SHIFT    = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Largest positive value of a signed w-bit activation.
  function automatic int unsigned out_max_f(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned NN_OUT_MAX = out_max_f(NN_OUT_W);

endpackage

// File: rtl/neuron_mac_acc_if.sv
// Start/bias control plus product-in and activation-out streams of one neuron.
interface neuron_mac_acc_if #(
  parameter int unsigned PROD_W = nn_pkg::NN_PROD_W,
  parameter int unsigned OUT_W  = nn_pkg::NN_OUT_W
) ();

  logic                     start;
  logic signed [PROD_W-1:0] bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] prod;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;

  modport master (
    output start, bias, in_valid, prod, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, prod, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/requant_relu.sv
// Combinational ReLU, arithmetic right-shift requantization and saturation to OUT_W.
module requant_relu
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = NN_ACC_W,
  parameter int unsigned SHIFT = NN_SHIFT,
  parameter int unsigned OUT_W = NN_OUT_W
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] act_c
);

  localparam int unsigned OUT_MAX = out_max_f(OUT_W);

  logic signed [ACC_W-1:0] q;

  // Negative sums clamp to zero before shifting, so -1 >>> n never leaks through.
  always_comb begin
    q     = sum >>> SHIFT;
    act_c = '0;
    if (!sum[ACC_W-1]) begin
      if (q > ACC_W'(OUT_MAX)) act_c = OUT_W'(OUT_MAX);
      else                     act_c = q[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_acc.sv
// Accumulates N_INPUTS signed products, adds bias and emits a ReLU'd, requantized activation.
module neuron_mac_acc
  import nn_pkg::*;
#(
  parameter int unsigned PROD_W   = NN_PROD_W,
  parameter int unsigned ACC_W    = NN_ACC_W,
  parameter int unsigned N_INPUTS = NN_N_INPUTS,
  parameter int unsigned OUT_W    = NN_OUT_W,
  parameter int unsigned SHIFT    = NN_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  neuron_mac_acc_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [PROD_W-1:0] bias_q, bias_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic signed [ACC_W-1:0]  sum_c;
  logic signed [OUT_W-1:0]  act_c;
  logic                     accept_c;
  logic                     last_c;

  assign sum_c    = acc_q + ACC_W'(bias_q);
  assign accept_c = (state_q == ST_ACCUM) && bus.in_valid && in_ready_q;
  assign last_c   = (cnt_q == CNT_W'(N_INPUTS - 1));

  requant_relu #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_requant (
    .sum   (sum_c),
    .act_c (act_c)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          bias_d  = bus.bias;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // prod is only looked at on an accepted beat, so idle-cycle X stays out of acc.
        if (accept_c) begin
          acc_d = acc_q + ACC_W'(bus.prod);
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        out_data_d = act_c;
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags follow the next state so they are registered alongside it.
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Drives two 4-input neurons (SHIFT=0 and SHIFT=7) in lockstep and checks them against an arithmetic model.
module tb_neuron_mac_acc;
  import nn_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_acc_if #(.PROD_W(NN_PROD_W), .OUT_W(NN_OUT_W)) if0 ();
  neuron_mac_acc_if #(.PROD_W(NN_PROD_W), .OUT_W(NN_OUT_W)) if7 ();

  neuron_mac_acc #(
    .PROD_W(NN_PROD_W), .ACC_W(NN_ACC_W), .N_INPUTS(N), .OUT_W(NN_OUT_W), .SHIFT(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  neuron_mac_acc #(
    .PROD_W(NN_PROD_W), .ACC_W(NN_ACC_W), .N_INPUTS(N), .OUT_W(NN_OUT_W), .SHIFT(7)
  ) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));

  int n_vec = 0;
  int n_err = 0;
  int p[4];

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact sum, ReLU, arithmetic shift, clamp to the signed activation max.
  function automatic int ref_act(input int prods[4], input int b, input int sh);
    longint s;
    longint lim;
    s = longint'(b);
    foreach (prods[i]) s += longint'(prods[i]);
    if (s < 0) return 0;
    s   = s >>> sh;
    lim = (longint'(1) << (NN_OUT_W - 1)) - 1;
    return (s > lim) ? int'(lim) : int'(s);
  endfunction

  task automatic set_in(input bit s, input int b, input bit v, input int pr);
    if0.start = s;  if7.start = s;
    if0.bias  = NN_PROD_W'(b);  if7.bias = NN_PROD_W'(b);
    if0.in_valid = v;  if7.in_valid = v;
    if0.prod  = NN_PROD_W'(pr);  if7.prod = NN_PROD_W'(pr);
  endtask

  task automatic set_oready(input bit r);
    if0.out_ready = r;  if7.out_ready = r;
  endtask

  task automatic chk_flags(input string tag, input bit iv, input bit ov, input bit bz);
    chk({tag, "_in_ready0"},  if0.in_ready,  iv);
    chk({tag, "_in_ready7"},  if7.in_ready,  iv);
    chk({tag, "_out_valid0"}, if0.out_valid, ov);
    chk({tag, "_out_valid7"}, if7.out_valid, ov);
    chk({tag, "_busy0"},      if0.busy,      bz);
    chk({tag, "_busy7"},      if7.busy,      bz);
  endtask

  task automatic chk_data(input string tag, input int e0, input int e7);
    chk({tag, "_data0"}, if0.out_data, e0);
    chk({tag, "_data7"}, if7.out_data, e7);
  endtask

  task automatic run_neuron(input string tag, input int b, input int prods[4],
                            input int gap_pct, input int hold, input bit spam);
    int e0;
    int e7;
    e0 = ref_act(prods, b, 0);
    e7 = ref_act(prods, b, 7);
    // Start cycle carries a valid junk beat that must not be accepted.
    @(negedge clk);
    set_in(1'b1, b, 1'b1, 12345);
    set_oready(spam);
    @(negedge clk);
    chk_flags({tag, "_accum"}, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(N); i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        set_in(spam, $urandom_range(4000), 1'b0, 0);
        if0.prod = 'x;  if7.prod = 'x;
        @(negedge clk);
        chk({tag, "_gap_in_ready"}, if0.in_ready, 1'b1);
      end
      set_in(spam, $urandom_range(4000), 1'b1, prods[i]);
      @(negedge clk);
    end
    set_in(spam, 0, 1'b0, 0);
    chk_flags({tag, "_finish"}, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_flags({tag, "_output"}, 1'b0, 1'b1, 1'b1);
    chk_data({tag, "_output"}, e0, e7);
    set_oready(1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk_flags({tag, "_hold"}, 1'b0, 1'b1, 1'b1);
      chk_data({tag, "_hold"}, e0, e7);
    end
    set_oready(1'b1);
    set_in(1'b0, 0, 1'b0, 0);
    @(negedge clk);
    chk_flags({tag, "_done"}, 1'b0, 1'b0, 1'b0);
    chk_data({tag, "_done"}, e0, e7);
    set_oready(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 0, 1'b0, 0);
    set_oready(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk_data("reset", 0, 0);
    rst = 1'b0;

    p = '{7, -15, 100, 20};
    run_neuron("basic", 0, p, 0, 0, 1'b0);
    p = '{1000, 1000, 1000, 1000};
    run_neuron("bias96", 96, p, 0, 0, 1'b0);
    p = '{16384, 16384, 16384, 16384};
    run_neuron("sat", 0, p, 0, 0, 1'b0);
    p = '{-100, 50, 20, 29};
    run_neuron("neg2", -1, p, 0, 0, 1'b0);
    p = '{0, 0, 0, 0};
    run_neuron("neg1", -1, p, 0, 0, 1'b0);
    p = '{7, -15, 100, 20};
    run_neuron("gaps", 0, p, 50, 0, 1'b0);
    run_neuron("hold5", 0, p, 0, 5, 1'b0);
    run_neuron("spam", 0, p, 30, 3, 1'b1);

    // Abort after two beats with a reset landing mid-cycle.
    @(negedge clk);
    set_in(1'b1, 500, 1'b0, 0);
    @(negedge clk);
    set_in(1'b0, 0, 1'b1, 30000);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_flags("abort", 1'b0, 1'b0, 1'b0);
    chk_data("abort", 0, 0);
    @(negedge clk);
    set_in(1'b0, 0, 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_flags("abort_idle", 1'b0, 1'b0, 1'b0);
    p = '{7, -15, 100, 20};
    run_neuron("fresh", 0, p, 0, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) p[i] = int'($urandom_range(65535)) - 32768;
      run_neuron("rand", int'($urandom_range(65535)) - 32768, p,
                 int'($urandom_range(60)), int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
